// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
// Sequential shift-and-add multiplier. A three-state controller feeds one
// shared 2*WIDTH-bit adder/subtractor, which accumulates one partial product
// per clock over WIDTH cycles.
//
// Optional feature macro: MULT_SIGNED_EN
//   defined   : two's-complement operands. The multiplicand is sign-extended,
//               and the last partial product is subtracted when the multiplier
//               MSB is set.
//   undefined : unsigned operation; the adder/subtractor op input is tied to add.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   start   in   operation request, sampled only while idle
//   A       in   WIDTH-bit multiplicand, captured on an accepted start
//   B       in   WIDTH-bit multiplier, captured on an accepted start
//   busy    out  high while running and during the done cycle
//   done    out  single-cycle pulse, product valid
//   product out  2*WIDTH-bit result, held until the next completion
// -----------------------------------------------------------------------------

// Shared 2*WIDTH-bit adder/subtractor: op_i=0 adds, op_i=1 subtracts.
module shift_add_addsub #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         op_i,
  output logic [W-1:0] sum_o
);
  assign sum_o = a_i + (b_i ^ {W{op_i}}) + W'(op_i);
endmodule

module shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PW-1:0]      product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [PW-1:0]      addend;
  logic [PW-1:0]      sum;
  logic               last_iter;
  logic               bit_set;
  logic               op;

  // Partial product for the current iteration.
  assign addend    = mcand_q << count_q;
  assign last_iter = (count_q == CNT_W'(WIDTH - 1));
  assign bit_set   = mplier_q[count_q];

`ifdef MULT_SIGNED_EN
  // Multiplier MSB carries weight -2^(WIDTH-1), so its partial product is subtracted.
  assign op = last_iter & bit_set;
`else
  assign op = 1'b0;
`endif

  shift_add_addsub #(.W(PW)) u_addsub (
    .a_i   (acc_q),
    .b_i   (addend),
    .op_i  (op),
    .sum_o (sum)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef MULT_SIGNED_EN
          mcand_d = {{WIDTH{A[WIDTH-1]}}, A};
`else
          mcand_d = {{WIDTH{1'b0}}, A};
`endif
          mplier_d = B;
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (bit_set) begin
          acc_d = sum;
        end
        count_d = count_q + 1'b1;
        if (last_iter) begin
          // Final accumulator value goes straight to the result register.
          product_d = bit_set ? sum : acc_q;
          count_d   = '0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flags are registered from the next state so they line up with it.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// tb_shift_add_multiplier
// Self-checking bench for shift_add_multiplier (WIDTH=8). Expected products
// go into a queue when an operation is issued and are popped when done pulses.
// The MULT_SIGNED_EN build switches the directed vectors and the reference
// model to two's complement.
// -----------------------------------------------------------------------------
module tb_shift_add_multiplier;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned PW    = 2 * WIDTH;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [PW-1:0]    product;

  int n_pass;
  int n_total;
  logic [PW-1:0] exp_q[$];

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product from a direct multiply.
  function automatic logic [PW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [PW-1:0] sa, sb;
`ifdef MULT_SIGNED_EN
    sa = PW'($signed(a));
    sb = PW'($signed(b));
    return PW'(sa * sb);
`else
    sa = '0;
    sb = '0;
    return PW'({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b});
`endif
  endfunction

  // Issue one operation, wait for done, check latency and the popped product,
  // then spend one idle cycle so the next call starts back-to-back.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [PW-1:0] expv, input string name);
    int cyc;
    logic [PW-1:0] e;
    exp_q.push_back(expv);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom;
    cyc = 0;
    while (done !== 1'b1 && cyc < 4 * WIDTH) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (cyc == WIDTH) n_pass++;
    else $display("FAIL %s latency: got %0d edges after start, expected %0d", name, cyc, WIDTH);
    e = exp_q.pop_front();
    n_total++;
    if (product === e) n_pass++;
    else $display("FAIL %s product: got %h, expected %h", name, product, e);
    @(negedge clk);
    n_total++;
    if (busy === 1'b0 && done === 1'b0) n_pass++;
    else $display("FAIL %s idle-after: busy=%b done=%b, expected 0 0", name, busy, done);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    n_total++;
    if (busy === 1'b0 && done === 1'b0 && product === '0) n_pass++;
    else $display("FAIL reset_state: busy=%b done=%b product=%h, expected 0 0 0000", busy, done, product);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // 7*5 with cycle-by-cycle busy/done tracking.
  task automatic test_basic();
    int bad_busy, bad_done;
    bad_busy = 0; bad_done = 0;
    exp_q.push_back(16'h0023);
    A = 8'd7; B = 8'd5; start = 1'b1;
    for (int k = 0; k <= WIDTH; k++) begin
      @(negedge clk);
      start = 1'b0;
      A = $urandom; B = $urandom;
      if (busy !== 1'b1) bad_busy++;
      if (done !== (k == WIDTH)) bad_done++;
    end
    n_total++;
    if (bad_busy == 0) n_pass++;
    else $display("FAIL basic_busy: busy low in %0d of %0d cycles, expected 0", bad_busy, WIDTH + 1);
    n_total++;
    if (bad_done == 0) n_pass++;
    else $display("FAIL basic_done: done wrong in %0d cycles, expected 0", bad_done);
    n_total++;
    if (product === exp_q.pop_front()) n_pass++;
    else $display("FAIL basic_product: got %h, expected 0023", product);
    @(negedge clk);
    n_total++;
    if (busy === 1'b0 && done === 1'b0 && product === 16'h0023) n_pass++;
    else $display("FAIL basic_after: busy=%b done=%b product=%h, expected 0 0 0023", busy, done, product);
  endtask

  task automatic test_corners();
`ifdef MULT_SIGNED_EN
    run_op(8'hFD, 8'h05, 16'hFFF1, "signed_m3x5");
    run_op(8'h80, 8'h80, 16'h4000, "signed_min_sq");
    run_op(8'h7F, 8'hFF, 16'hFF81, "signed_max_xm1");
    run_op(8'hFF, 8'hFF, 16'h0001, "signed_m1_sq");
`else
    run_op(8'hFF, 8'hFF, 16'hFE01, "max_sq");
    run_op(8'h80, 8'h80, 16'h4000, "msb_sq");
`endif
    run_op(8'h00, 8'd200, 16'h0000, "zero_a");
    run_op(8'd200, 8'h00, 16'h0000, "zero_b");
  endtask

  // start held high with toggling operands: only the first capture matters,
  // and the next operation is accepted only in the idle cycle after done.
  task automatic test_start_held();
    int cyc;
    exp_q.push_back(16'h0078);
    A = 8'd12; B = 8'd10; start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (done !== 1'b1 && cyc < 4 * WIDTH) begin
      A = $urandom; B = $urandom;
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (done === 1'b1 && product === exp_q.pop_front()) n_pass++;
    else $display("FAIL held_product: done=%b product=%h, expected 1 0078", done, product);
    A = 8'd3; B = 8'd4;
    exp_q.push_back(16'h000C);
    @(negedge clk);
    n_total++;
    if (busy === 1'b0) n_pass++;
    else $display("FAIL held_gap: busy=%b in cycle after done, expected 0", busy);
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom;
    n_total++;
    if (busy === 1'b1) n_pass++;
    else $display("FAIL held_restart: busy=%b, expected 1", busy);
    cyc = 0;
    while (done !== 1'b1 && cyc < 4 * WIDTH) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (done === 1'b1 && product === exp_q.pop_front()) n_pass++;
    else $display("FAIL held_second: done=%b product=%h, expected 1 000c", done, product);
    @(negedge clk);
  endtask

  // Reset four edges into RUN aborts without a done pulse.
  task automatic test_reset_mid_run();
    int seen_done;
    seen_done = 0;
    A = 8'd100; B = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    n_total++;
    if (busy === 1'b0 && done === 1'b0 && product === '0) n_pass++;
    else $display("FAIL abort_state: busy=%b done=%b product=%h, expected 0 0 0000", busy, done, product);
    reset = 1'b0; start = 1'b0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    n_total++;
    if (seen_done == 0) n_pass++;
    else $display("FAIL abort_quiet: activity in %0d cycles after reset, expected 0", seen_done);
    run_op(8'd2, 8'd3, 16'h0006, "after_abort");
  endtask

  // Random operands issued back-to-back against the reference model.
  task automatic test_back_to_back();
    logic [WIDTH-1:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      run_op(a, b, model(a, b), "random");
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_corners();
    test_start_held();
    test_reset_mid_run();
    test_back_to_back();
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
